// File: rtl/urisc_pkg.sv
// Shared types for the IF/ID instruction queue: control state encoding and the
// default {pc, inst} entry layout.
package urisc_pkg;

   localparam int PC_W_DEF   = 16;
   localparam int INST_W_DEF = 16;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } fq_state_t;

   typedef struct packed {
      logic [PC_W_DEF-1:0]   pc;
      logic [INST_W_DEF-1:0] inst;
   } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// DEPTH-entry register file holding queued {pc, inst} words: one synchronous
// write port and one asynchronous read port. Contents are not reset.
module fq_storage #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // write port
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ifid_queue.sv
// IF/ID instruction buffer: DEPTH-entry {pc, inst} FIFO with valid/ready handshakes,
// redirect flush, terminal halt and optional same-cycle bypass when empty.
module ifid_queue
   import urisc_pkg::*;
#(
   parameter int PC_W   = PC_W_DEF,
   parameter int INST_W = INST_W_DEF,
   parameter int DEPTH  = 4,
   parameter int BYPASS = 1,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_valid_p1,
   input  logic [PC_W-1:0]   push_pc_p1,
   input  logic [INST_W-1:0] push_inst_p1,
   output logic              push_ready_p1,
   output logic              pop_valid_p1,
   output logic [PC_W-1:0]   pop_pc_p1,
   output logic [INST_W-1:0] pop_inst_p1,
   input  logic              pop_ready_p1,
   input  logic              flush_p1,
   input  logic              halt_p1,
   output logic [CNT_W-1:0]  count_p1,
   output logic              halted_p1
);

   localparam int   PTR_W = $clog2(DEPTH);
   localparam int   ENT_W = PC_W + INST_W;
   localparam logic BYP   = (BYPASS != 0);

   fq_state_t        state_q, state_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             halted_q, halted_d;
   logic [ENT_W-1:0] last_q, last_d;

   logic [ENT_W-1:0] head_s, rd_data_s, wr_data_s;
   logic             run_ok_s, empty_s, full_s;
   logic             push_ready_s, pop_valid_s;
   logic             push_fire_s, pop_fire_s, push_store_s, pop_mem_s;

   // control state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic; halt dominates flush and is terminal until reset
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN, FLUSH: begin
            if (halt_p1) begin
               state_d = HALT;
            end else if (flush_p1) begin
               state_d = FLUSH;
            end else begin
               state_d = RUN;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = RUN;
      endcase
   end

   // handshake outputs; push_ready deliberately ignores pop_ready
   always_comb begin
      run_ok_s     = (state_q == RUN) && !flush_p1 && !halt_p1;
      empty_s      = (count_q == {CNT_W{1'b0}});
      full_s       = (count_q == CNT_W'(DEPTH));
      push_ready_s = run_ok_s && !full_s;
      pop_valid_s  = run_ok_s && (!empty_s || (BYP && push_valid_p1));
      halted_d     = (state_d == HALT);
   end

   // datapath: fire decode, head mux, pointer and occupancy update
   always_comb begin
      push_fire_s  = push_valid_p1 && push_ready_s;
      pop_fire_s   = pop_valid_s && pop_ready_p1;
      // a pop from an empty queue can only be the bypassed push, which is never stored
      push_store_s = push_fire_s && !(empty_s && pop_fire_s);
      pop_mem_s    = pop_fire_s && !empty_s;
      wr_data_s    = {push_pc_p1, push_inst_p1};

      if (!empty_s) begin
         head_s = rd_data_s;
      end else if (BYP && push_valid_p1) begin
         head_s = wr_data_s;
      end else begin
         head_s = last_q;
      end
      last_d = head_s;

      if (!run_ok_s) begin
         rd_ptr_d = {PTR_W{1'b0}};
         wr_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         rd_ptr_d = pop_mem_s    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
         wr_ptr_d = push_store_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
         case ({push_store_s, pop_mem_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // pointer, occupancy, halt flag and last-head registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= {PTR_W{1'b0}};
         wr_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
         halted_q <= 1'b0;
         last_q   <= {ENT_W{1'b0}};
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         halted_q <= halted_d;
         last_q   <= last_d;
      end
   end

   fq_storage #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_storage (
      .clk     (clk),
      .we_i    (push_store_s),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_data_s),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data_s)
   );

   assign push_ready_p1 = push_ready_s;
   assign pop_valid_p1  = pop_valid_s;
   assign pop_pc_p1     = head_s[ENT_W-1:INST_W];
   assign pop_inst_p1   = head_s[INST_W-1:0];
   assign count_p1      = count_q;
   assign halted_p1     = halted_q;

endmodule

// File: tb/tb_ifid_queue.sv
// Self-checking bench for ifid_queue: a queue scoreboard tracks accepted pushes
// and compares them as the bypass (DEPTH=4) DUT pops; a second DUT covers BYPASS=0.
module tb_ifid_queue;
   import urisc_pkg::*;

   localparam int DEPTH = 4;

   logic        clk, rst;
   logic        push_valid, pop_ready, flush, halt;
   logic [15:0] push_pc, push_inst;
   logic        push_ready, pop_valid, halted;
   logic [15:0] pop_pc, pop_inst;
   logic [2:0]  count;

   logic        nb_push_valid, nb_pop_ready;
   logic [15:0] nb_push_pc, nb_push_inst;
   logic        nb_push_ready, nb_pop_valid, nb_halted;
   logic [15:0] nb_pop_pc, nb_pop_inst;
   logic [2:0]  nb_count;

   int n_cmp = 0;
   int n_err = 0;

   fq_entry_t exp_q[$];
   fq_state_t m_state;

   ifid_queue #(.PC_W(16), .INST_W(16), .DEPTH(DEPTH), .BYPASS(1)) u_dut (
      .clk(clk), .rst(rst),
      .push_valid_p1(push_valid), .push_pc_p1(push_pc), .push_inst_p1(push_inst),
      .push_ready_p1(push_ready),
      .pop_valid_p1(pop_valid), .pop_pc_p1(pop_pc), .pop_inst_p1(pop_inst),
      .pop_ready_p1(pop_ready), .flush_p1(flush), .halt_p1(halt),
      .count_p1(count), .halted_p1(halted)
   );

   ifid_queue #(.PC_W(16), .INST_W(16), .DEPTH(DEPTH), .BYPASS(0)) u_dut_nb (
      .clk(clk), .rst(rst),
      .push_valid_p1(nb_push_valid), .push_pc_p1(nb_push_pc), .push_inst_p1(nb_push_inst),
      .push_ready_p1(nb_push_ready),
      .pop_valid_p1(nb_pop_valid), .pop_pc_p1(nb_pop_pc), .pop_inst_p1(nb_pop_inst),
      .pop_ready_p1(nb_pop_ready), .flush_p1(1'b0), .halt_p1(1'b0),
      .count_p1(nb_count), .halted_p1(nb_halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock of the bypass DUT: drive, check comb outputs against the model,
   // advance the model, clock, then check registered outputs.
   task automatic step(input logic pv, input logic [15:0] pc, input logic [15:0] inst,
                       input logic pr, input logic fl, input logic ht, output logic pushed);
      logic      run_ok, exp_pr, exp_pv, push_f, pop_f;
      fq_entry_t head;
      int        m_count;
      push_valid = pv; push_pc = pc; push_inst = inst;
      pop_ready = pr; flush = fl; halt = ht;
      #1;
      m_count = exp_q.size();
      run_ok  = (m_state == RUN) && !fl && !ht;
      exp_pr  = run_ok && (m_count != DEPTH);
      exp_pv  = run_ok && ((m_count != 0) || pv);
      check_val("push_ready", {31'd0, push_ready}, {31'd0, exp_pr});
      check_val("pop_valid", {31'd0, pop_valid}, {31'd0, exp_pv});
      if (exp_pv) begin
         head = (m_count != 0) ? exp_q[0] : '{pc: pc, inst: inst};
         check_val("pop_pc", {16'd0, pop_pc}, {16'd0, head.pc});
         check_val("pop_inst", {16'd0, pop_inst}, {16'd0, head.inst});
      end
      push_f = pv && exp_pr;
      pop_f  = pr && exp_pv;
      pushed = push_f;
      if (ht || m_state == HALT) begin
         m_state = HALT;
         exp_q.delete();
      end else if (fl) begin
         m_state = FLUSH;
         exp_q.delete();
      end else begin
         m_state = RUN;
         if (pop_f && m_count != 0) void'(exp_q.pop_front());
         if (push_f && !(m_count == 0 && pop_f)) exp_q.push_back('{pc: pc, inst: inst});
      end
      @(posedge clk);
      #1;
      check_val("count", {29'd0, count}, exp_q.size());
      check_val("halted", {31'd0, halted}, {31'd0, (m_state == HALT)});
   endtask

   task automatic do_reset(input logic pv, input logic pr);
      rst = 1'b1; push_valid = pv; pop_ready = pr; flush = 1'b0; halt = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
      exp_q.delete();
      m_state = RUN;
      #1;
      check_val("rst_count", {29'd0, count}, 32'd0);
      check_val("rst_halted", {31'd0, halted}, 32'd0);
      check_val("rst_push_ready", {31'd0, push_ready}, 32'd1);
      check_val("rst_pop_valid", {31'd0, pop_valid}, 32'd0);
   endtask

   initial begin
      logic        acc;
      logic [15:0] nxt;
      rst = 1'b1; push_valid = 1'b0; pop_ready = 1'b0; flush = 1'b0; halt = 1'b0;
      push_pc = 16'h0; push_inst = 16'h0;
      nb_push_valid = 1'b0; nb_pop_ready = 1'b0; nb_push_pc = 16'h0; nb_push_inst = 16'h0;
      repeat (2) @(posedge clk);
      do_reset(1'b0, 1'b0);
      check_val("nb_rst_count", {29'd0, nb_count}, 32'd0);
      check_val("nb_rst_pop_valid", {31'd0, nb_pop_valid}, 32'd0);

      // 1: two pushes held, then two ordered pops
      step(1'b1, 16'h1000, 16'hA001, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 16'h1002, 16'hA002, 1'b0, 1'b0, 1'b0, acc);
      check_val("t1_count2", {29'd0, count}, 32'd2);
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, acc);
      check_val("t1_count0", {29'd0, count}, 32'd0);
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, acc);

      // 2: bypass on empty queue, then the same push on the BYPASS=0 instance
      step(1'b1, 16'h2000, 16'hB000, 1'b1, 1'b0, 1'b0, acc);
      check_val("t2_byp_count", {29'd0, count}, 32'd0);
      push_valid = 1'b0; pop_ready = 1'b0;
      nb_push_valid = 1'b1; nb_push_pc = 16'h2000; nb_push_inst = 16'hB000; nb_pop_ready = 1'b1;
      #1;
      check_val("t2_nb_pop_valid0", {31'd0, nb_pop_valid}, 32'd0);
      check_val("t2_nb_push_ready", {31'd0, nb_push_ready}, 32'd1);
      @(posedge clk); #1;
      nb_push_valid = 1'b0;
      #1;
      check_val("t2_nb_pop_valid1", {31'd0, nb_pop_valid}, 32'd1);
      check_val("t2_nb_pop_inst", {16'd0, nb_pop_inst}, 32'h0000B000);
      check_val("t2_nb_count1", {29'd0, nb_count}, 32'd1);
      @(posedge clk); #1;
      nb_pop_ready = 1'b0;
      check_val("t2_nb_count0", {29'd0, nb_count}, 32'd0);

      // 3: fill to DEPTH, then hold push+pop through pointer wrap, then drain
      for (int i = 1; i <= DEPTH; i++)
         step(1'b1, 16'h3000 + 16'(i), 16'(i), 1'b0, 1'b0, 1'b0, acc);
      check_val("t3_full_count", {29'd0, count}, 32'd4);
      step(1'b1, 16'h3005, 16'd5, 1'b0, 1'b0, 1'b0, acc);
      nxt = 16'd5;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 16'h3000 + nxt, nxt, 1'b1, 1'b0, 1'b0, acc);
         if (acc) nxt = nxt + 16'd1;
      end
      for (int i = 0; i < DEPTH + 1; i++)
         step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, acc);
      check_val("t3_drained", {29'd0, count}, 32'd0);

      // 4: flush with count=3 and a push pending
      for (int i = 0; i < 3; i++)
         step(1'b1, 16'h4000 + 16'(i), 16'hC000 + 16'(i), 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 16'h4010, 16'hC010, 1'b0, 1'b1, 1'b0, acc);
      check_val("t4_flush_count", {29'd0, count}, 32'd0);
      step(1'b1, 16'h4020, 16'hC020, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 16'h4030, 16'hC030, 1'b0, 1'b0, 1'b0, acc);
      check_val("t4_push_accepted", {31'd0, acc}, 32'd1);
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, acc);

      // 5: halt and flush together with count=2
      step(1'b1, 16'h5000, 16'hD000, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 16'h5002, 16'hD002, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 16'h5004, 16'hD004, 1'b1, 1'b1, 1'b1, acc);
      check_val("t5_halted", {31'd0, halted}, 32'd1);
      for (int i = 0; i < 20; i++)
         step(1'b1, 16'h5100 + 16'(i), 16'hD100, 1'b1, 1'b0, 1'b0, acc);
      do_reset(1'b0, 1'b0);

      // 6: reset while count=3 with push and pop firing
      for (int i = 0; i < 3; i++)
         step(1'b1, 16'h6000 + 16'(i), 16'hE000 + 16'(i), 1'b0, 1'b0, 1'b0, acc);
      push_pc = 16'h6010; push_inst = 16'hE010;
      do_reset(1'b1, 1'b1);
      step(1'b1, 16'h6020, 16'hE020, 1'b0, 1'b0, 1'b0, acc);
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, acc);
      check_val("t6_final_count", {29'd0, count}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
